// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, word-line, write-through data cache
// with tree pseudo-LRU replacement and a blocking miss/store handshake.
// Optional feature: define CACHE_STATS_EN to add saturating hit/miss counters.
module set_assoc_cache #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  hit_o,
  output logic                  mem_req_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
`endif
);

  localparam int unsigned SET_BITS  = $clog2(SETS);
  localparam int unsigned TAG_WIDTH = DATA_WIDTH - SET_BITS - 2;
  localparam int unsigned WAY_BITS  = $clog2(WAYS);
  localparam int unsigned PLRU_W    = WAYS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WAYS-1:0]       valid_mem [SETS];
  logic [PLRU_W-1:0]     plru_mem  [SETS];
  logic [TAG_WIDTH-1:0]  tag_mem   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem  [SETS][WAYS];

  logic [SET_BITS-1:0]   set_idx;
  logic [TAG_WIDTH-1:0]  tag;
  logic [WAYS-1:0]       set_valid;
  logic [PLRU_W-1:0]     set_plru;
  logic                  lookup_hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [WAY_BITS-1:0]   victim_way;
  logic [WAY_BITS-1:0]   touch_way;
  logic                  fill_we;
  logic                  wr_we;
  logic                  plru_we;
  logic                  unused_addr_bits;

  assign set_idx          = addr_i[SET_BITS+1:2];
  assign tag              = addr_i[DATA_WIDTH-1:SET_BITS+2];
  assign set_valid        = valid_mem[set_idx];
  assign set_plru         = plru_mem[set_idx];
  assign unused_addr_bits = ^addr_i[1:0];
  assign hit_o            = !rst && req_valid_i && lookup_hit;

  // Tree PLRU: each node bit points toward the victim half; touching a way
  // flips every node on its path to point away from it.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] cur,
                                                   input logic [WAY_BITS-1:0] way);
    logic [PLRU_W-1:0] nxt;
    logic              dir;
    int unsigned       node;
    nxt  = cur;
    node = 0;
    for (int unsigned lvl = 0; lvl < WAY_BITS; lvl++) begin
      dir                   = way[WAY_BITS'(WAY_BITS - 1 - lvl)];
      nxt[WAY_BITS'(node)]  = ~dir;
      node                  = 2 * node + 1 + 32'(dir);
    end
    return nxt;
  endfunction

  // Tag lookup across all ways of the addressed set.
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    hit_data   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (set_valid[WAY_BITS'(w)] && (tag_mem[set_idx][WAY_BITS'(w)] == tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_BITS'(w);
        hit_data   = data_mem[set_idx][WAY_BITS'(w)];
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise follow the PLRU tree.
  always_comb begin
    int unsigned node;
    logic        found;
    victim_way = '0;
    found      = 1'b0;
    node       = 0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!set_valid[WAY_BITS'(w)]) begin
        victim_way = WAY_BITS'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned lvl = 0; lvl < WAY_BITS; lvl++) begin
        node = 2 * node + 1 + 32'(set_plru[WAY_BITS'(node)]);
      end
      victim_way = WAY_BITS'(node - PLRU_W);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, handshake outputs and array write enables.
  always_comb begin
    state_next  = state;
    ready_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    fill_we     = 1'b0;
    wr_we       = 1'b0;
    plru_we     = 1'b0;
    touch_way   = hit_way;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (req_write_i) begin
            state_next = WRITE;
          end else if (lookup_hit) begin
            ready_o = 1'b1;
            rdata_o = hit_data;
            plru_we = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_i[DATA_WIDTH-1:2], 2'b00};
        if (mem_ack_i) begin
          fill_we    = 1'b1;
          plru_we    = 1'b1;
          touch_way  = victim_way;
          state_next = IDLE;
        end
      end
      WRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {addr_i[DATA_WIDTH-1:2], 2'b00};
        mem_wdata_o = wdata_i;
        if (mem_ack_i) begin
          ready_o    = 1'b1;
          wr_we      = lookup_hit;
          plru_we    = lookup_hit;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      ready_o = 1'b0;
      rdata_o = '0;
      fill_we = 1'b0;
      wr_we   = 1'b0;
      plru_we = 1'b0;
    end
  end

  // Valid and PLRU state; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_mem[SET_BITS'(s)] <= '0;
        plru_mem[SET_BITS'(s)]  <= '0;
      end
    end else begin
      if (fill_we) valid_mem[set_idx][victim_way] <= 1'b1;
      if (plru_we) plru_mem[set_idx] <= plru_touch(set_plru, touch_way);
    end
  end

  // Tag and data arrays; not reset, guarded by the valid bits.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[set_idx][victim_way]  <= tag;
      data_mem[set_idx][victim_way] <= mem_rdata_i;
    end
    if (wr_we) data_mem[set_idx][hit_way] <= wdata_i;
  end

`ifdef CACHE_STATS_EN
  // One count per IDLE lookup with a request present; saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (state == IDLE && req_valid_i) begin
      if (lookup_hit) begin
        if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
      end else begin
        if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed bench for set_assoc_cache (WAYS=2, SETS=8).
// Expected load data / store data are queued when a request is driven and
// popped when the cache completes it; the memory side is a small word model.
module tb_set_assoc_cache;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        hit;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  set_assoc_cache #(.WAYS(2), .SETS(8), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_write_i (req_write),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .ready_o     (ready),
    .hit_o       (hit),
    .mem_req_o   (mem_req),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load: answer any fill after 'lat' wait cycles; check hit, data, latency.
  task automatic do_load(input logic [31:0] a, input bit exp_miss, input int lat);
    int cyc;
    int wait_n;
    int ready_cyc;
    bit done;
    bit filled;
    exp_q.push_back(mem_model[a]);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = a;
    wdata     = '0;
    cyc = 0; wait_n = 0; ready_cyc = -1; done = 1'b0; filled = 1'b0;
    #1;
    check("load_hit_o", 32'(hit), 32'(!exp_miss));
    while (!done && cyc < 40) begin
      if (ready) begin
        done      = 1'b1;
        ready_cyc = cyc;
        check("load_rdata", rdata, exp_q.pop_front());
      end else if (mem_req) begin
        check("fill_is_read", 32'(mem_write), 32'd0);
        check("fill_addr", mem_addr, a & 32'hFFFF_FFFC);
        if (wait_n == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model[a];
          filled    = 1'b1;
        end
        wait_n++;
      end
      if (!done) begin
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cyc++;
        #1;
      end
    end
    if (!done) void'(exp_q.pop_front());
    check("load_done", 32'(done), 32'd1);
    check("load_missed", 32'(filled), 32'(exp_miss));
    check("load_latency", 32'(ready_cyc), exp_miss ? 32'(lat + 2) : 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Store: write-through; ready must coincide with the memory ack.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat);
    int cyc;
    int wait_n;
    int done_cyc;
    bit done;
    exp_q.push_back(d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    addr      = a;
    wdata     = d;
    cyc = 0; wait_n = 0; done_cyc = -1; done = 1'b0;
    #1;
    while (!done && cyc < 40) begin
      if (mem_req) begin
        check("store_mem_write", 32'(mem_write), 32'd1);
        check("store_addr", mem_addr, a & 32'hFFFF_FFFC);
        if (wait_n == lat) begin
          mem_ack = 1'b1;
          #1;
          check("store_ready_on_ack", 32'(ready), 32'd1);
          check("store_wdata", mem_wdata, exp_q.pop_front());
          mem_model[a] = d;
          done     = 1'b1;
          done_cyc = cyc;
        end else begin
          check("store_stall", 32'(ready), 32'd0);
        end
        wait_n++;
      end else begin
        check("store_stall", 32'(ready), 32'd0);
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
        #1;
      end
    end
    if (!done) void'(exp_q.pop_front());
    check("store_done", 32'(done), 32'd1);
    check("store_latency", 32'(done_cyc), 32'(lat + 1));
    @(negedge clk);
    mem_ack   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    mem_model[32'h040] = 32'hDEAD_BEEF;
    mem_model[32'h044] = 32'h4444_4444;
    mem_model[32'h060] = 32'h6060_6060;
    mem_model[32'h080] = 32'h8080_8080;
    mem_model[32'h0A0] = 32'hA0A0_A0A0;
    mem_model[32'h100] = 32'h0100_0100;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = 32'h040;
    wdata     = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst_mem_req", 32'(mem_req), 32'd0);
    check("post_rst_mem_write", 32'(mem_write), 32'd0);
    check("post_rst_mem_addr", mem_addr, 32'd0);
    check("post_rst_mem_wdata", mem_wdata, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);

    // Cold miss then zero-stall hit.
    do_load(32'h040, 1'b1, 2);
    do_load(32'h040, 1'b0, 0);

    // Three lines in set 0: the third evicts the PLRU way (0x040).
    do_load(32'h060, 1'b1, 0);
    do_load(32'h080, 1'b1, 1);
    do_load(32'h060, 1'b0, 0);
    do_load(32'h040, 1'b1, 0);

    // Store hit updates cache; the reload comes from the cache.
    do_store(32'h040, 32'h1234_5678, 2);
    do_load(32'h040, 1'b0, 0);

    // Store miss does not allocate.
    do_store(32'h0A0, 32'hA0A0_0001, 0);
    do_load(32'h0A0, 1'b1, 1);
    do_load(32'h060, 1'b1, 0);
    do_load(32'h0A0, 1'b0, 0);

    // Another set is independent.
    do_load(32'h044, 1'b1, 3);
    do_load(32'h044, 1'b0, 0);

    // A stray ack while idle is ignored.
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("idle_ack_mem_req", 32'(mem_req), 32'd0);
    check("idle_ack_ready", 32'(ready), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("idle_ack_still_idle", 32'(mem_req), 32'd0);
    do_load(32'h044, 1'b0, 0);

    // Reset during a fill with a coincident ack: nothing installed.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = 32'h100;
    #1;
    for (int i = 0; i < 10 && !mem_req; i++) begin
      @(negedge clk);
      #1;
    end
    check("fill_before_rst", 32'(mem_req), 32'd1);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    #1;
    check("rst_fill_ready", 32'(ready), 32'd0);
    check("rst_fill_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    req_valid = 1'b0;
    #1;
    check("rst_fill_mem_req_drop", 32'(mem_req), 32'd0);
    do_load(32'h100, 1'b1, 1);

    // Write hit followed by a fill in the same set: PLRU sees the write.
    do_load(32'h040, 1'b1, 0);
    do_store(32'h100, 32'hCAFE_F00D, 1);
    do_load(32'h080, 1'b1, 0);
    do_load(32'h100, 1'b0, 0);
    do_load(32'h040, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative, word-line, write-through data cache between the RISC-V core's load/store path and data memory. It generalises the fixed 2-way cache in way count, set count and widths, and adds what that block lacks: synchronous reset, stall/handshake on both sides, real write handling and tree pseudo-LRU replacement. On a miss it stalls the core, fetches from memory and installs the word. It never returns data from an invalid line.

## Interface
- WAYS, 2: associativity; power of two, 2..8.
- SETS, 8: number of sets; power of two, ≥2.
- DATA_WIDTH, 32: data and address width.
- Derived (localparam): SET_BITS = log2(SETS); TAG_WIDTH = DATA_WIDTH − SET_BITS − 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core access request.
- req_write_i  in  1  1 = store, 0 = load.
- addr_i  in  DATA_WIDTH  byte address; bits [1:0] ignored.
- wdata_i  in  DATA_WIDTH  store data.
- rdata_o  out  DATA_WIDTH  load data; valid when ready_o && !req_write_i.
- ready_o  out  1  request completes this cycle; core stalls while low.
- hit_o  out  1  lookup hit (combinational, only meaningful in IDLE).
- mem_req_o  out  1  memory request.
- mem_write_o  out  1  memory store.
- mem_addr_o  out  DATA_WIDTH  word-aligned memory address.
- mem_wdata_o  out  DATA_WIDTH  memory store data.
- mem_rdata_i  in  DATA_WIDTH  memory load data; valid with mem_ack_i.
- mem_ack_i  in  1  memory completes request this cycle.

## Operation
- Address split: set = addr_i[SET_BITS+1:2]; tag = addr_i[DATA_WIDTH−1:SET_BITS+2].
- Per way per set: valid bit, tag, data word. Per set: WAYS−1 tree-PLRU bits.
- Hit: valid && tag match in any way. Exactly one way can match; a duplicate tag is never installed.
- FSM states:
  - IDLE: on read hit, rdata_o = hit way's data and ready_o = 1 in the same cycle; PLRU points away from the hit way. On read miss, go to FILL. On any write, go to WRITE.
  - FILL: mem_req_o = 1, mem_write_o = 0, mem_addr_o = {addr_i[DATA_WIDTH−1:2], 2'b00}. On mem_ack_i, install mem_rdata_i into the victim way, set valid, update PLRU, go to IDLE. The retried access then hits.
  - WRITE: mem_req_o = 1, mem_write_o = 1, mem_wdata_o = wdata_i. On mem_ack_i: if hit, update that way's data and PLRU; ready_o = 1; go to IDLE. No write-allocate on miss.
- Victim selection: lowest-index invalid way if any, else the way indicated by PLRU.
- Core holds req_valid_i/addr_i/wdata_i/req_write_i stable while ready_o = 0. Memory holds nothing before ack. mem_req_o stays high until ack.
- Reset: all valid bits and PLRU bits cleared, FSM to IDLE. Data and tag arrays are not reset.

## Timing
- Reset values: ready_o = 0 and hit_o = 0 while rst is high. After reset: mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0, rdata_o = 0.
- Read hit: 0 extra cycles; ready_o is combinational from lookup.
- Read miss: FILL entered next edge; ready_o first high on the cycle after the ack cycle (miss latency = memory latency + 2).
- Write: ready_o high in the mem_ack_i cycle; array update at that edge.
- req_valid_i = 0 in IDLE: ready_o = 0, no state change.
- rst mid-FILL/WRITE: abandon the transaction; mem_req_o drops next cycle; no array update even if mem_ack_i coincides.
- mem_ack_i in IDLE: ignored.
- Write hit and fill to the same set on consecutive accesses: the PLRU update uses the post-write state; no lost update.

## Configuration
- CACHE_STATS_EN: when defined, adds outputs hit_count_o and miss_count_o (32 bits each, saturating, cleared by rst).
  - Each IDLE lookup with req_valid_i counts once. A retried access after a fill counts as a hit.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset, then load 0x0000_0040 → FILL issued with mem_addr_o = 0x40; ack with 0xDEAD_BEEF → ready_o = 1, rdata_o = 0xDEADBEEF two cycles later; repeat load hits with 0 stall.
- WAYS=2, SETS=8: load 0x040, 0x060, 0x080 (all set 0) → third fill evicts 0x040 (PLRU); load 0x060 hits, load 0x040 misses.
- Store 0x1234_5678 to cached 0x040 → mem_write_o = 1 until ack; subsequent load returns 0x12345678 without memory access.
- Store to uncached 0x0A0 → memory write only; following load of 0x0A0 misses.
- Assert rst during FILL with mem_ack_i high the same cycle → no install; the load afterwards misses again.
- With CACHE_STATS_EN: 1 miss + 3 hits to the same address → miss_count_o = 1, hit_count_o = 4.
